// File: rtl/aes.sv
// Four-round 64-bit SPN cipher feeding a ciphertext FIFO. A write encrypts and pushes.
// A read pops and decrypts the entry with the key that is present at read time.
module aes #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data,
  input  logic [63:0] key,
  input  logic        we,
  input  logic        re,
  output logic [63:0] encrypt_data,
  output logic [63:0] decrypt_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [ROUNDS:0][63:0] ks_t;

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      enc_q, enc_d, dec_q, dec_d;
  logic [63:0]      enc_c;
  logic             pop_c, push_c;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    case (n)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] n);
    case (n)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] w, input logic [1:0] n);
    case (n)
      2'd0:    rotl16 = w;
      2'd1:    rotl16 = {w[11:0], w[15:12]};
      2'd2:    rotl16 = {w[7:0],  w[15:8]};
      default: rotl16 = {w[3:0],  w[15:4]};
    endcase
  endfunction

  function automatic logic [63:0] sub64(input logic [63:0] s, input logic inv);
    for (int i = 0; i < 16; i++) sub64[4*i +: 4] = inv ? sbox_inv(s[4*i +: 4]) : sbox(s[4*i +: 4]);
  endfunction

  // Lane i rotates by 4i; the inverse is the complementary left rotation.
  function automatic logic [63:0] shift64(input logic [63:0] s, input logic inv);
    for (int i = 0; i < 4; i++)
      shift64[16*i +: 16] = rotl16(s[16*i +: 16], inv ? 2'(4 - i) : 2'(i));
  endfunction

  function automatic logic [63:0] mix64(input logic [63:0] s, input logic inv);
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w = s[16*i +: 16];
      mix64[16*i +: 16] = inv ? (w ^ rotl16(w, 2'd2) ^ rotl16(w, 2'd3))
                              : (w ^ rotl16(w, 2'd1) ^ rotl16(w, 2'd2));
    end
  endfunction

  function automatic ks_t key_sched(input logic [63:0] k);
    key_sched[0] = k;
    for (int r = 0; r < int'(ROUNDS); r++)
      key_sched[r+1] = {key_sched[r][50:0], key_sched[r][63:51]} ^ 64'(r + 1);
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] p, input logic [63:0] k);
    ks_t         ks;
    logic [63:0] s;
    ks = key_sched(k);
    s  = p;
    for (int r = 0; r < int'(ROUNDS); r++) begin
      s = shift64(sub64(s ^ ks[r], 1'b0), 1'b0);
      if (r < int'(ROUNDS) - 1) s = mix64(s, 1'b0);
    end
    encrypt = s ^ ks[ROUNDS];
  endfunction

  function automatic logic [63:0] decrypt(input logic [63:0] c, input logic [63:0] k);
    ks_t         ks;
    logic [63:0] s;
    ks = key_sched(k);
    s  = c ^ ks[ROUNDS];
    for (int r = int'(ROUNDS) - 1; r >= 0; r--) begin
      if (r < int'(ROUNDS) - 1) s = mix64(s, 1'b1);
      s = sub64(shift64(s, 1'b1), 1'b1) ^ ks[r];
    end
    decrypt = s;
  endfunction

  // A pop at the same edge frees a slot for a push into a full FIFO.
  always_comb begin
    pop_c   = re && (count_q != '0);
    push_c  = we && ((count_q != CNT_W'(DEPTH)) || pop_c);
    enc_c   = encrypt(data, key);
    enc_d   = enc_q;
    dec_d   = dec_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (we) enc_d = enc_c;
    if (pop_c) begin
      dec_d  = decrypt(mem_q[rptr_q], key);
      rptr_d = rptr_q + PTR_W'(1);
    end
    if (push_c) wptr_d = wptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      enc_q   <= '0;
      dec_q   <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      enc_q   <= enc_d;
      dec_q   <= dec_d;
    end
  end

  // Storage is not reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem_q[wptr_q] <= enc_c;
  end

  assign encrypt_data = enc_q;
  assign decrypt_data = dec_q;

endmodule

// File: tb/tb_aes.sv
// Scoreboard bench for aes: a nibble-level reference cipher plus a queue model of the FIFO,
// checking both outputs after every clock edge.
module tb_aes;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [63:0] data, key;
  logic [63:0] encrypt_data, decrypt_data;

  aes dut (
    .clk(clk), .rst(rst), .data(data), .key(key), .we(we), .re(re),
    .encrypt_data(encrypt_data), .decrypt_data(decrypt_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pt;
    logic [63:0] key;
  } entry_t;

  entry_t      sb_q[$];
  logic [63:0] exp_enc, exp_dec;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_sub(input logic [63:0] s, input bit inv);
    logic [3:0] sb [16] = '{4'hC,4'h5,4'h6,4'hB,4'h9,4'h0,4'hA,4'hD,4'h3,4'hE,4'hF,4'h8,4'h4,4'h7,4'h1,4'h2};
    logic [3:0] si [16] = '{4'h5,4'hE,4'hF,4'h8,4'hC,4'h1,4'h2,4'hD,4'hB,4'h4,4'h6,4'h3,4'h0,4'h7,4'h9,4'hA};
    logic [63:0] o;
    for (int j = 0; j < 16; j++) o[4*j +: 4] = inv ? si[s[4*j +: 4]] : sb[s[4*j +: 4]];
    return o;
  endfunction

  // Nibble k of lane i takes nibble (k-i) forward, (k+i) inverse.
  function automatic logic [63:0] m_shift(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        o[16*i + 4*k +: 4] = s[16*i + 4*(inv ? (k + i) % 4 : (k + 4 - i) % 4) +: 4];
    return o;
  endfunction

  function automatic logic [63:0] m_mix(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        o[16*i + 4*k +: 4] = s[16*i + 4*k +: 4]
                           ^ s[16*i + 4*((k + (inv ? 2 : 3)) % 4) +: 4]
                           ^ s[16*i + 4*((k + (inv ? 1 : 2)) % 4) +: 4];
    return o;
  endfunction

  function automatic logic [63:0] m_rk(input logic [63:0] k, input int r);
    logic [63:0] x = k;
    for (int j = 1; j <= r; j++) x = ((x << 13) | (x >> 51)) ^ 64'(j);
    return x;
  endfunction

  function automatic logic [63:0] m_enc(input logic [63:0] p, input logic [63:0] k);
    logic [63:0] s = p;
    for (int r = 0; r < 4; r++) begin
      s = m_shift(m_sub(s ^ m_rk(k, r), 0), 0);
      if (r < 3) s = m_mix(s, 0);
    end
    return s ^ m_rk(k, 4);
  endfunction

  function automatic logic [63:0] m_dec(input logic [63:0] c, input logic [63:0] k);
    logic [63:0] s = c ^ m_rk(k, 4);
    for (int r = 3; r >= 0; r--) begin
      if (r < 3) s = m_mix(s, 1);
      s = m_sub(m_shift(s, 1), 1) ^ m_rk(k, r);
    end
    return s;
  endfunction

  task automatic do_reset(input logic w, input logic r);
    @(negedge clk);
    rst = 1'b1; we = w; re = r; data = 64'hDEAD_BEEF_0000_0001; key = 64'h1;
    @(posedge clk); #1;
    sb_q.delete();
    exp_enc = '0;
    exp_dec = '0;
    check_eq("rst_enc", encrypt_data, exp_enc);
    check_eq("rst_dec", decrypt_data, exp_dec);
    rst = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  // One clock: model the pop (pre-edge state), then the push, then compare both outputs.
  task automatic cycle(input string tag, input logic w, input logic r,
                       input logic [63:0] d, input logic [63:0] k);
    entry_t e;
    bit     pop_ok, push_ok;
    @(negedge clk);
    we = w; re = r; data = d; key = k;
    pop_ok  = r && (sb_q.size() > 0);
    push_ok = w && (sb_q.size() < 16 || pop_ok);
    if (w) exp_enc = m_enc(d, k);
    if (pop_ok) begin
      e = sb_q.pop_front();
      exp_dec = (k == e.key) ? e.pt : m_dec(m_enc(e.pt, e.key), k);
    end
    if (push_ok) sb_q.push_back('{pt: d, key: k});
    @(posedge clk); #1;
    check_eq({tag, "_enc"}, encrypt_data, exp_enc);
    check_eq({tag, "_dec"}, decrypt_data, exp_dec);
    we = 1'b0; re = 1'b0;
  endtask

  logic [63:0] p_arr [10];
  logic [63:0] k_arr [10];
  logic [63:0] p, k;

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; data = '0; key = '0;

    // Known vector round trip.
    do_reset(1'b0, 1'b0);
    p = 64'h0123_4567_89AB_CDEF;
    k = 64'h0F1E_2D3C_4B5A_6978;
    cycle("t1_wr", 1'b1, 1'b0, p, k);
    cycle("t1_rd", 1'b1 & 1'b0, 1'b1, '0, k);
    check_eq("t1_plain", decrypt_data, p);

    // Ten random entries, each with its own key, drained in order.
    for (int i = 0; i < 10; i++) begin
      p_arr[i] = {$urandom, $urandom};
      k_arr[i] = {$urandom, $urandom};
      cycle("t2_wr", 1'b1, 1'b0, p_arr[i], k_arr[i]);
    end
    for (int i = 0; i < 10; i++) begin
      cycle("t2_rd", 1'b0, 1'b1, '0, k_arr[i]);
      check_eq("t2_plain", decrypt_data, p_arr[i]);
    end

    // Empty read holds zero; wrong key yields garbage.
    do_reset(1'b0, 1'b0);
    cycle("t3_empty", 1'b0, 1'b1, '0, 64'h5);
    p = {$urandom, $urandom};
    k = {$urandom, $urandom};
    cycle("t3_wr", 1'b1, 1'b0, p, k);
    cycle("t3_badkey", 1'b0, 1'b1, '0, k ^ 64'h1);
    check_eq("t3_differs", 64'(decrypt_data != p), 64'd1);

    // Overflow: the 17th ciphertext is shown but dropped.
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) cycle("t4_wr", 1'b1, 1'b0, 64'(i), '0);
    check_eq("t4_enc17", encrypt_data, m_enc(64'd17, '0));
    for (int i = 1; i <= 16; i++) begin
      cycle("t4_rd", 1'b0, 1'b1, '0, '0);
      check_eq("t4_plain", decrypt_data, 64'(i));
    end
    cycle("t4_under", 1'b0, 1'b1, '0, '0);
    check_eq("t4_hold", decrypt_data, 64'd16);

    // Simultaneous write/read on empty, full and partially filled FIFO.
    do_reset(1'b0, 1'b0);
    cycle("t5_e_wr", 1'b1, 1'b1, 64'hAAAA, 64'h77);
    cycle("t5_e_rd", 1'b0, 1'b1, '0, 64'h77);
    check_eq("t5_e_plain", decrypt_data, 64'hAAAA);
    for (int i = 0; i < 16; i++) cycle("t5_f_fill", 1'b1, 1'b0, 64'(100 + i), 64'h9);
    cycle("t5_f_both", 1'b1, 1'b1, 64'hBEEF, 64'h9);
    check_eq("t5_f_pop", decrypt_data, 64'd100);
    for (int i = 0; i < 16; i++) cycle("t5_f_drain", 1'b0, 1'b1, '0, 64'h9);
    check_eq("t5_f_last", decrypt_data, 64'hBEEF);
    cycle("t5_f_empty", 1'b0, 1'b1, '0, 64'h9);
    for (int i = 0; i < 5; i++) cycle("t5_5_fill", 1'b1, 1'b0, 64'(200 + i), 64'h3);
    cycle("t5_5_both", 1'b1, 1'b1, 64'h205, 64'h3);
    for (int i = 0; i < 5; i++) cycle("t5_5_drain", 1'b0, 1'b1, '0, 64'h3);
    check_eq("t5_5_last", decrypt_data, 64'h205);
    cycle("t5_5_empty", 1'b0, 1'b1, '0, 64'h3);

    // Reset with entries queued, while strobes are high.
    for (int i = 0; i < 3; i++) cycle("t6_fill", 1'b1, 1'b0, 64'(300 + i), 64'h4);
    do_reset(1'b1, 1'b1);
    cycle("t6_empty", 1'b0, 1'b1, '0, 64'h4);
    p = {$urandom, $urandom};
    k = {$urandom, $urandom};
    cycle("t6_wr", 1'b1, 1'b0, p, k);
    cycle("t6_rd", 1'b0, 1'b1, '0, k);
    check_eq("t6_plain", decrypt_data, p);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
